udp_oe_csr_mc: RTL and testbench

Multi-channel control/status register block for the UDP offload engine. Exposes one Avalon-MM slave to the host and drives the shared FPGA endpoint configuration plus per-channel host endpoint fields to NUM_CHANNELS TX/RX channel pairs. Per channel it also:
- generates stretched soft resets;
- accumulates saturating packet counters;
- computes the IPv4 header checksum in hardware (replaces the software-written checksum CSR).

---
 rtl/udp_oe_csr_mc.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_udp_oe_csr_mc.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_oe_csr_mc.sv
// udp_oe_csr_mc: host CSR block for the multi-channel UDP offload engine.
//
// The host reaches this block through one Avalon-MM slave with 64-bit words
// and a fixed read latency of one cycle. The block drives:
//   - the shared FPGA endpoint configuration (MAC, IP, UDP port, netmask,
//     payload size, loopback) and a global stretched soft reset (csr_rst);
//   - per-channel host endpoint fields, packed with channel c in slice c;
//   - per-channel stretched tx/rx soft resets;
//   - per-channel saturating tx/rx packet counters, with optional clear on read;
//   - per-channel IPv4 header checksums, produced by one round-robin engine.
//
// Ports:
//   clk, reset                         clock and synchronous active-high reset
//   avmm_*                             Avalon-MM slave (waitrequest is tied low)
//   fpga_*, payload_per_packet,
//   intrabsp_txrx_loopback, csr_rst    shared configuration and global reset
//   host_mac_adr/ip_adr/udp_port       per-channel host endpoint fields
//   checksum_ip, checksum_valid        per-channel header checksum and valid flag
//   tx_rst, rx_rst                     per-channel soft resets
//   tx/rx_pkt_done, tx/rx_sm_state     per-channel status inputs
module udp_oe_csr_mc #(
   parameter int          NUM_CHANNELS     = 4,
   parameter int          RST_PULSE_CYCLES = 16,
   parameter int          CNT_W            = 32,
   parameter bit          CLR_ON_READ      = 1'b1,
   parameter logic [15:0] PAYLOAD_DEFAULT  = 16'd1024
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [7:0]                   avmm_address,
   input  logic                         avmm_read,
   input  logic                         avmm_write,
   input  logic [63:0]                  avmm_writedata,
   output logic [63:0]                  avmm_readdata,
   output logic                         avmm_readdatavalid,
   output logic                         avmm_waitrequest,
   output logic [47:0]                  fpga_mac_adr,
   output logic [31:0]                  fpga_ip_adr,
   output logic [15:0]                  fpga_udp_port,
   output logic [31:0]                  fpga_netmask,
   output logic [15:0]                  payload_per_packet,
   output logic                         intrabsp_txrx_loopback,
   output logic                         csr_rst,
   output logic [48*NUM_CHANNELS-1:0]   host_mac_adr,
   output logic [32*NUM_CHANNELS-1:0]   host_ip_adr,
   output logic [16*NUM_CHANNELS-1:0]   host_udp_port,
   output logic [16*NUM_CHANNELS-1:0]   checksum_ip,
   output logic [NUM_CHANNELS-1:0]      checksum_valid,
   output logic [NUM_CHANNELS-1:0]      tx_rst,
   output logic [NUM_CHANNELS-1:0]      rx_rst,
   input  logic [NUM_CHANNELS-1:0]      tx_pkt_done,
   input  logic [NUM_CHANNELS-1:0]      rx_pkt_done,
   input  logic [16*NUM_CHANNELS-1:0]   tx_sm_state,
   input  logic [16*NUM_CHANNELS-1:0]   rx_sm_state
);

   localparam int N    = NUM_CHANNELS;
   localparam int CH_W = (N > 1) ? $clog2(N) : 1;
   localparam int RC_W = $clog2(RST_PULSE_CYCLES + 1);
   localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RST_PULSE_CYCLES);
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_SUM, S_FOLD, S_STORE} cks_state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Address decode: channel windows are 8 words wide starting at 0x10.
   logic [7:0]  ch_off;
   logic [4:0]  ch_sel;
   logic [2:0]  reg_off;
   logic        ch_hit;
   logic [N-1:0] sel;
   logic [N-1:0] mark;
   logic        glob_mark;

   assign ch_off  = avmm_address - 8'h10;
   assign ch_sel  = ch_off[7:3];
   assign reg_off = avmm_address[2:0];
   assign ch_hit  = (avmm_address >= 8'h10) && ({27'd0, ch_sel} < 32'(N));
   assign avmm_waitrequest = 1'b0;

   // A header operand change invalidates every channel that uses it.
   assign glob_mark = avmm_write && (avmm_address == 8'h02 || avmm_address == 8'h04);

   logic [47:0]      host_mac_q  [N];
   logic [31:0]      host_ip_q   [N];
   logic [15:0]      host_port_q [N];
   logic [15:0]      cks_q       [N];
   logic [RC_W-1:0]  tx_rc       [N];
   logic [RC_W-1:0]  rx_rc       [N];
   logic [RC_W-1:0]  csr_rc;
   logic [CNT_W-1:0] tx_pc       [N];
   logic [CNT_W-1:0] rx_pc       [N];
   logic [N-1:0]     dirty;
   logic [N-1:0]     redirty;

   assign csr_rst        = (csr_rc != '0);
   assign checksum_valid = ~dirty;

   for (genvar c = 0; c < N; c++) begin : g_ch
      assign sel[c]  = ch_hit && (ch_sel == 5'(c));
      assign mark[c] = glob_mark | (avmm_write && sel[c] && reg_off == 3'd1);
      assign host_mac_adr [48*c +: 48] = host_mac_q[c];
      assign host_ip_adr  [32*c +: 32] = host_ip_q[c];
      assign host_udp_port[16*c +: 16] = host_port_q[c];
      assign checksum_ip  [16*c +: 16] = cks_q[c];
      // The global soft reset overrides every channel reset.
      assign tx_rst[c] = csr_rst | (tx_rc[c] != '0);
      assign rx_rst[c] = csr_rst | (rx_rc[c] != '0);
   end

   // Configuration registers (untouched by csr_rst).
   always_ff @(posedge clk) begin
      if (reset) begin
         fpga_mac_adr           <= '0;
         fpga_ip_adr            <= '0;
         fpga_udp_port          <= '0;
         fpga_netmask           <= '0;
         payload_per_packet     <= PAYLOAD_DEFAULT;
         intrabsp_txrx_loopback <= 1'b0;
         for (int c = 0; c < N; c++) begin
            host_mac_q[c]  <= '0;
            host_ip_q[c]   <= '0;
            host_port_q[c] <= '0;
         end
      end else if (avmm_write) begin
         case (avmm_address)
            8'h01: fpga_mac_adr <= avmm_writedata[47:0];
            8'h02: begin
               fpga_ip_adr   <= avmm_writedata[31:0];
               fpga_udp_port <= avmm_writedata[47:32];
            end
            8'h03: fpga_netmask <= avmm_writedata[31:0];
            8'h04: begin
               payload_per_packet     <= avmm_writedata[15:0];
               intrabsp_txrx_loopback <= avmm_writedata[32];
            end
            default: ;
         endcase
         for (int c = 0; c < N; c++) begin
            if (sel[c] && reg_off == 3'd0) host_mac_q[c] <= avmm_writedata[47:0];
            if (sel[c] && reg_off == 3'd1) begin
               host_ip_q[c]   <= avmm_writedata[31:0];
               host_port_q[c] <= avmm_writedata[47:32];
            end
         end
      end
   end

   // Soft-reset pulse stretchers; a new start request reloads the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         csr_rc <= '0;
         for (int c = 0; c < N; c++) begin
            tx_rc[c] <= '0;
            rx_rc[c] <= '0;
         end
      end else begin
         if (avmm_write && avmm_address == 8'h05 && avmm_writedata[0])
            csr_rc <= RC_LOAD;
         else if (csr_rc != '0)
            csr_rc <= csr_rc - RC_W'(1);
         for (int c = 0; c < N; c++) begin
            if (avmm_write && sel[c] && reg_off == 3'd2 && avmm_writedata[0])
               tx_rc[c] <= RC_LOAD;
            else if (tx_rc[c] != '0)
               tx_rc[c] <= tx_rc[c] - RC_W'(1);
            if (avmm_write && sel[c] && reg_off == 3'd2 && avmm_writedata[1])
               rx_rc[c] <= RC_LOAD;
            else if (rx_rc[c] != '0)
               rx_rc[c] <= rx_rc[c] - RC_W'(1);
         end
      end
   end

   // Packet counters. A strobe coinciding with a clearing read is kept as 1.
   always_ff @(posedge clk) begin
      for (int c = 0; c < N; c++) begin
         if (reset || csr_rst) begin
            tx_pc[c] <= '0;
            rx_pc[c] <= '0;
         end else begin
            if (CLR_ON_READ && avmm_read && sel[c] && reg_off == 3'd4)
               tx_pc[c] <= tx_pkt_done[c] ? CNT_W'(1) : '0;
            else if (tx_pkt_done[c])
               tx_pc[c] <= sat_inc(tx_pc[c]);
            if (CLR_ON_READ && avmm_read && sel[c] && reg_off == 3'd5)
               rx_pc[c] <= rx_pkt_done[c] ? CNT_W'(1) : '0;
            else if (rx_pkt_done[c])
               rx_pc[c] <= sat_inc(rx_pc[c]);
         end
      end
   end

   // Read mux, captured one cycle after the request.
   logic [63:0] rdata;
   always_comb begin
      rdata = '0;
      case (avmm_address)
         8'h00: rdata = {56'h5544_504F_4532_00, 8'(N)};
         8'h01: rdata = {16'h0, fpga_mac_adr};
         8'h02: rdata = {16'h0, fpga_udp_port, fpga_ip_adr};
         8'h03: rdata = {32'h0, fpga_netmask};
         8'h04: rdata = {31'h0, intrabsp_txrx_loopback, 16'h0, payload_per_packet};
         8'h05: rdata = {63'h0, csr_rst};
         default: ;
      endcase
      for (int c = 0; c < N; c++) begin
         if (sel[c]) begin
            case (reg_off)
               3'd0: rdata = {16'h0, host_mac_q[c]};
               3'd1: rdata = {16'h0, host_port_q[c], host_ip_q[c]};
               3'd2: rdata = {62'h0, rx_rst[c], tx_rst[c]};
               3'd3: rdata = {47'h0, ~dirty[c], cks_q[c]};
               3'd4: rdata = {16'h0, tx_sm_state[16*c +: 16], 32'(tx_pc[c])};
               3'd5: rdata = {16'h0, rx_sm_state[16*c +: 16], 32'(rx_pc[c])};
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) avmm_readdatavalid <= 1'b0;
      else       avmm_readdatavalid <= avmm_read;
      if (avmm_read) avmm_readdata <= rdata;
   end

   // Round-robin pick: lowest dirty channel at or after last_ch+1, else wrap.
   cks_state_t      state;
   logic [CH_W-1:0] last_ch, cur_ch, start_ch, hi_ch, lo_ch, pick_ch;
   logic            hi_found;
   logic [3:0]      step;
   logic [31:0]     src_ip_p0, dst_ip_p0;
   logic [15:0]     len_p0, word;
   logic [19:0]     sum_p1;

   always_comb begin
      start_ch = (last_ch == LAST_CH) ? '0 : last_ch + CH_W'(1);
      hi_found = 1'b0;
      hi_ch    = '0;
      lo_ch    = '0;
      for (int j = N - 1; j >= 0; j--) begin
         if (dirty[j]) begin
            lo_ch = CH_W'(j);
            if (j >= int'(start_ch)) begin
               hi_found = 1'b1;
               hi_ch    = CH_W'(j);
            end
         end
      end
      pick_ch = hi_found ? hi_ch : lo_ch;
   end

   always_comb begin
      word = '0;
      case (step)
         4'd0: word = 16'h4500;
         4'd1: word = len_p0;
         4'd2: word = 16'h0000;
         4'd3: word = 16'h4000;
         4'd4: word = 16'h4011;
         4'd5: word = src_ip_p0[31:16];
         4'd6: word = src_ip_p0[15:0];
         4'd7: word = dst_ip_p0[31:16];
         4'd8: word = dst_ip_p0[15:0];
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         dirty   <= '1;
         redirty <= '0;
         last_ch <= LAST_CH;
         cur_ch  <= '0;
         step    <= '0;
         for (int c = 0; c < N; c++) cks_q[c] <= '0;
      end else begin
         case (state)
            // p0: operand snapshot
            S_IDLE: if (|dirty) begin
               cur_ch           <= pick_ch;
               src_ip_p0        <= fpga_ip_adr;
               dst_ip_p0        <= host_ip_q[pick_ch];
               len_p0           <= payload_per_packet + 16'd28;
               redirty[pick_ch] <= 1'b0;
               sum_p1           <= '0;
               step             <= '0;
               state            <= S_SUM;
            end
            // p1: word accumulation
            S_SUM: begin
               sum_p1 <= sum_p1 + {4'h0, word};
               if (step == 4'd8) begin
                  step  <= '0;
                  state <= S_FOLD;
               end else begin
                  step <= step + 4'd1;
               end
            end
            // p2: end-around carry; two folds cover the worst-case 20-bit sum
            S_FOLD: begin
               sum_p1 <= {4'h0, sum_p1[15:0]} + {16'h0, sum_p1[19:16]};
               if (step == 4'd1) state <= S_STORE;
               else              step  <= step + 4'd1;
            end
            S_STORE: begin
               cks_q[cur_ch] <= ~sum_p1[15:0];
               if (!redirty[cur_ch]) dirty[cur_ch] <= 1'b0;
               last_ch <= cur_ch;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
         // Operand writes win over a same-cycle pickup or store.
         for (int c = 0; c < N; c++) begin
            if (mark[c]) begin
               dirty[c]   <= 1'b1;
               redirty[c] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_udp_oe_csr_mc.sv
// Testbench for udp_oe_csr_mc: directed table of register accesses plus
// hand-written sequences for pulses, counters and the checksum engine.
module tb_udp_oe_csr_mc;

   localparam int NC = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [7:0]        avmm_address;
   logic              avmm_read, avmm_write;
   logic [63:0]       avmm_writedata, avmm_readdata;
   logic              avmm_readdatavalid, avmm_waitrequest;
   logic [47:0]       fpga_mac_adr;
   logic [31:0]       fpga_ip_adr;
   logic [15:0]       fpga_udp_port;
   logic [31:0]       fpga_netmask;
   logic [15:0]       payload_per_packet;
   logic              intrabsp_txrx_loopback, csr_rst;
   logic [48*NC-1:0]  host_mac_adr;
   logic [32*NC-1:0]  host_ip_adr;
   logic [16*NC-1:0]  host_udp_port, checksum_ip;
   logic [NC-1:0]     checksum_valid, tx_rst, rx_rst, tx_pkt_done, rx_pkt_done;
   logic [16*NC-1:0]  tx_sm_state, rx_sm_state;

   always #5 clk = ~clk;

   udp_oe_csr_mc #(
      .NUM_CHANNELS(NC), .RST_PULSE_CYCLES(16), .CNT_W(4),
      .CLR_ON_READ(1'b1), .PAYLOAD_DEFAULT(16'd1024)
   ) dut (
      .clk(clk), .reset(reset),
      .avmm_address(avmm_address), .avmm_read(avmm_read), .avmm_write(avmm_write),
      .avmm_writedata(avmm_writedata), .avmm_readdata(avmm_readdata),
      .avmm_readdatavalid(avmm_readdatavalid), .avmm_waitrequest(avmm_waitrequest),
      .fpga_mac_adr(fpga_mac_adr), .fpga_ip_adr(fpga_ip_adr),
      .fpga_udp_port(fpga_udp_port), .fpga_netmask(fpga_netmask),
      .payload_per_packet(payload_per_packet),
      .intrabsp_txrx_loopback(intrabsp_txrx_loopback), .csr_rst(csr_rst),
      .host_mac_adr(host_mac_adr), .host_ip_adr(host_ip_adr),
      .host_udp_port(host_udp_port), .checksum_ip(checksum_ip),
      .checksum_valid(checksum_valid), .tx_rst(tx_rst), .rx_rst(rx_rst),
      .tx_pkt_done(tx_pkt_done), .rx_pkt_done(rx_pkt_done),
      .tx_sm_state(tx_sm_state), .rx_sm_state(rx_sm_state)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          is_wr;
      logic [7:0]  addr;
      logic [63:0] data;   // write data, or expected read data
   } vec_t;

   vec_t vecs[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [63:0] d);
      avmm_address   = a;
      avmm_writedata = d;
      avmm_write     = 1'b1;
      tick();
      avmm_write = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [63:0] d);
      avmm_address = a;
      avmm_read    = 1'b1;
      tick();
      avmm_read = 1'b0;
      check($sformatf("rdvalid_%02h", a), 64'(avmm_readdatavalid), 64'd1);
      d = avmm_readdata;
   endtask

   task automatic wait_valid(input logic [NC-1:0] mask, input string name);
      int n;
      n = 0;
      while ((checksum_valid & mask) != mask && n < 200) begin
         tick();
         n++;
      end
      check(name, 64'(checksum_valid & mask), 64'(mask));
   endtask

   // Reference IPv4 header checksum over the fixed header template.
   function automatic logic [15:0] cks_model(input logic [31:0] src, input logic [31:0] dst,
                                             input logic [15:0] pay);
      logic [31:0] s;
      logic [15:0] len;
      len = pay + 16'd28;
      s = 32'h4500 + 32'(len) + 32'h0000 + 32'h4000 + 32'h4011
        + 32'(src[31:16]) + 32'(src[15:0]) + 32'(dst[31:16]) + 32'(dst[15:0]);
      s = (s & 32'hFFFF) + (s >> 16);
      s = (s & 32'hFFFF) + (s >> 16);
      return ~s[15:0];
   endfunction

   initial begin
      logic [63:0] d;
      int n, hi_cnt, rx_cnt, bad;

      reset = 1'b1;
      avmm_address = '0; avmm_read = 1'b0; avmm_write = 1'b0; avmm_writedata = '0;
      tx_pkt_done = '0; rx_pkt_done = '0;
      tx_sm_state = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
      rx_sm_state = {16'hB003, 16'hB002, 16'hB001, 16'hB000};

      vecs.push_back('{1'b1, 8'h01, 64'hFFFF_1122_3344_5566});
      vecs.push_back('{1'b0, 8'h01, 64'h0000_1122_3344_5566});
      vecs.push_back('{1'b1, 8'h02, 64'h0000_1234_C0A8_0001});
      vecs.push_back('{1'b0, 8'h02, 64'h0000_1234_C0A8_0001});
      vecs.push_back('{1'b1, 8'h03, 64'hFFFF_FFFF_FFFF_FF00});
      vecs.push_back('{1'b0, 8'h03, 64'h0000_0000_FFFF_FF00});
      vecs.push_back('{1'b1, 8'h04, 64'hABCD_0001_0000_0400});
      vecs.push_back('{1'b0, 8'h04, 64'h0000_0001_0000_0400});
      vecs.push_back('{1'b0, 8'h00, 64'h5544_504F_4532_0004});
      vecs.push_back('{1'b1, 8'h00, 64'h1234_5678_9ABC_DEF0});
      vecs.push_back('{1'b0, 8'h00, 64'h5544_504F_4532_0004});
      vecs.push_back('{1'b0, 8'h06, 64'h0});
      vecs.push_back('{1'b0, 8'h0F, 64'h0});
      vecs.push_back('{1'b1, 8'h10, 64'h0000_AABB_CCDD_EEFF});
      vecs.push_back('{1'b0, 8'h10, 64'h0000_AABB_CCDD_EEFF});
      vecs.push_back('{1'b1, 8'h11, 64'h0000_5678_C0A8_0002});
      vecs.push_back('{1'b0, 8'h11, 64'h0000_5678_C0A8_0002});
      vecs.push_back('{1'b1, 8'h18, 64'h0000_0102_0304_0506});
      vecs.push_back('{1'b0, 8'h18, 64'h0000_0102_0304_0506});
      vecs.push_back('{1'b1, 8'h30, 64'h0000_1111_2222_3333});
      vecs.push_back('{1'b0, 8'h30, 64'h0});
      vecs.push_back('{1'b0, 8'h16, 64'h0});
      vecs.push_back('{1'b0, 8'h2F, 64'h0});
      vecs.push_back('{1'b1, 8'h14, 64'hFFFF_FFFF_FFFF_FFFF});
      vecs.push_back('{1'b0, 8'h14, 64'h0000_A000_0000_0000});
      vecs.push_back('{1'b0, 8'h25, 64'h0000_B002_0000_0000});

      // Reset state
      repeat (3) tick();
      check("rst_valid", 64'(checksum_valid), 64'h0);
      check("rst_cks", 64'(checksum_ip), 64'h0);
      check("rst_soft", 64'({csr_rst, tx_rst, rx_rst}), 64'h0);
      check("rst_payload", 64'(payload_per_packet), 64'd1024);
      check("rst_fpga_ip", 64'(fpga_ip_adr), 64'h0);
      check("rst_rdvalid", 64'(avmm_readdatavalid), 64'h0);
      check("rst_waitreq", 64'(avmm_waitrequest), 64'h0);

      reset = 1'b0;
      tick();
      check("release_valid", 64'(checksum_valid), 64'h0);
      n = 0;
      while (!checksum_valid[0] && n < 100) begin
         tick();
         n++;
      end
      check("latency_ch0", 64'(n), 64'd12);
      wait_valid('1, "release_all_valid");
      for (int c = 0; c < NC; c++)
         check($sformatf("release_cks%0d", c), 64'(checksum_ip[16*c +: 16]),
               64'(cks_model(32'h0, 32'h0, 16'd1024)));

      // Register table
      foreach (vecs[i]) begin
         if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].data);
         else begin
            rd(vecs[i].addr, d);
            check($sformatf("vec%0d_a%02h", i, vecs[i].addr), d, vecs[i].data);
         end
      end
      check("port_mac", 64'(fpga_mac_adr), 64'h1122_3344_5566);
      check("port_udp", 64'(fpga_udp_port), 64'h1234);
      check("port_netmask", 64'(fpga_netmask), 64'hFFFF_FF00);
      check("port_loopback", 64'(intrabsp_txrx_loopback), 64'h1);
      check("port_host_mac0", 64'(host_mac_adr[47:0]), 64'hAABB_CCDD_EEFF);
      check("port_host_mac1", 64'(host_mac_adr[95:48]), 64'h0102_0304_0506);
      check("port_host_udp0", 64'(host_udp_port[15:0]), 64'h5678);

      // Checksum with real addresses
      wait_valid('1, "cfg_all_valid");
      rd(8'h13, d);
      check("cks_ch0_read", d, 64'h1_B57D);
      check("cks_ch1_port", 64'(checksum_ip[31:16]),
            64'(cks_model(32'hC0A8_0001, 32'h0, 16'd1024)));

      // Channel soft-reset pulse length and extension
      wr(8'h12, 64'h3);
      check("pulse_start", 64'({tx_rst, rx_rst}), 64'h11);
      hi_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (tx_rst[0]) hi_cnt++;
         tick();
      end
      check("pulse_len", 64'(hi_cnt), 64'd16);

      wr(8'h12, 64'h1);
      hi_cnt = 0;
      rx_cnt = 0;
      for (int i = 1; i < 60; i++) begin
         if (tx_rst[0]) hi_cnt++;
         if (rx_rst[0]) rx_cnt++;
         if (i == 10) begin
            avmm_address = 8'h12; avmm_writedata = 64'h1; avmm_write = 1'b1;
         end
         tick();
         avmm_write = 1'b0;
      end
      check("pulse_extend", 64'(hi_cnt), 64'd26);
      check("pulse_rx_idle", 64'(rx_cnt), 64'd0);

      wr(8'h12, 64'h2);
      rd(8'h12, d);
      check("ctl_read_rx", d, 64'h2);
      repeat (20) tick();

      // Global soft reset
      wr(8'h05, 64'h1);
      check("csr_forces", 64'({csr_rst, tx_rst, rx_rst}), 64'h1FF);
      rd(8'h05, d);
      check("csr_read", d, 64'h1);
      rd(8'h12, d);
      check("csr_ctl_read", d, 64'h3);
      for (int i = 0; i < 3; i++) begin
         tx_pkt_done[1] = 1'b1;
         tick();
         tx_pkt_done[1] = 1'b0;
      end
      repeat (20) tick();
      check("csr_done", 64'({csr_rst, tx_rst, rx_rst}), 64'h0);
      check("csr_cfg_kept", 64'(fpga_ip_adr), 64'hC0A8_0001);
      rd(8'h1C, d);
      check("csr_cnt_held", d, 64'h0000_A001_0000_0000);

      // Packet counters
      for (int i = 0; i < 5; i++) begin
         tx_pkt_done[1] = 1'b1;
         tick();
         tx_pkt_done[1] = 1'b0;
         tick();
      end
      rd(8'h1C, d);
      check("cnt_five", d, 64'h0000_A001_0000_0005);
      rd(8'h1C, d);
      check("cnt_cleared", d, 64'h0000_A001_0000_0000);
      avmm_address = 8'h1C; avmm_read = 1'b1; tx_pkt_done[1] = 1'b1;
      tick();
      avmm_read = 1'b0; tx_pkt_done[1] = 1'b0;
      check("cnt_same_cycle_pre", avmm_readdata, 64'h0000_A001_0000_0000);
      rd(8'h1C, d);
      check("cnt_same_cycle_post", d, 64'h0000_A001_0000_0001);
      rx_pkt_done[1] = 1'b1;
      repeat (20) tick();
      rx_pkt_done[1] = 1'b0;
      rd(8'h1D, d);
      check("cnt_saturate", d, 64'h0000_B001_0000_000F);
      rd(8'h14, d);
      check("cnt_ch0_untouched", d, 64'h0000_A000_0000_0000);

      // Host IP rewritten while channel 2 is being summed
      wait_valid('1, "pre_redirty_valid");
      wr(8'h21, 64'h0000_0000_C0A8_0003);
      check("dirty_holds_old", 64'(checksum_ip[47:32]),
            64'(cks_model(32'hC0A8_0001, 32'h0, 16'd1024)));
      repeat (3) tick();
      wr(8'h21, 64'h0000_0000_C0A8_0004);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (checksum_valid[2]) bad++;
         tick();
      end
      check("redirty_store_invalid", 64'(bad), 64'd0);
      wait_valid(4'b0100, "redirty_recompute_valid");
      check("redirty_value", 64'(checksum_ip[47:32]),
            64'(cks_model(32'hC0A8_0001, 32'hC0A8_0004, 16'd1024)));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
